// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-pc selection: redirect, sequential advance, or hold.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_d, pc_q;

    // Redirect targets are forced word-aligned.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i & ~ADDR_W'(3);
        end else if (advance_i) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: req/ack toward imem, valid/stall register toward decode.
// Optional perf counters (fetch_count, squash_count) are built when FETCH_PERF_EN is defined.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_b,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]       fetch_count,
    output logic [15:0]       squash_count,
`endif
    output logic [ADDR_W-1:0] pc4
);

    fetch_state_t      state_d, state_q;
    logic              squash_d, squash_q;
    logic              inst_valid_d, inst_valid_q;
    logic [INST_W-1:0] inst_d, inst_q;
    logic [ADDR_W-1:0] inst_pc_d, inst_pc_q;
    logic [ADDR_W-1:0] pc;
    logic              advance;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst_b         (rst_b),
        .redirect_i    (redirect_valid),
        .redirect_pc_i (redirect_pc),
        .advance_i     (advance),
        .pc_o          (pc)
    );

    always_comb begin
        state_d      = state_q;
        squash_d     = squash_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        advance      = 1'b0;
        if (redirect_valid) begin
            inst_valid_d = 1'b0;
            state_d      = StFetch;
            // An un-acked request still completes at the old address; mark it for discard.
            if (state_q == StFetch) begin
                squash_d = !imem_ack;
            end
        end else begin
            case (state_q)
                StIdle: state_d = StFetch;
                StFetch: begin
                    if (imem_ack) begin
                        if (squash_q) begin
                            squash_d = 1'b0;
                        end else begin
                            inst_d       = imem_rdata;
                            inst_pc_d    = pc;
                            inst_valid_d = 1'b1;
                            advance      = 1'b1;
                            state_d      = StHold;
                        end
                    end
                end
                StHold: begin
                    if (!stall) begin
                        inst_valid_d = 1'b0;
                        state_d      = StFetch;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= StIdle;
            squash_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            squash_q     <= squash_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q;
    logic [15:0] squash_count_q;
    logic        consume, discard;

    assign consume = inst_valid_q & !stall & !redirect_valid;
    // Only HOLD holds a valid instruction, so at most one discard event per cycle.
    assign discard = ((state_q == StFetch) & imem_ack & (squash_q | redirect_valid)) |
                     (inst_valid_q & redirect_valid);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            fetch_count_q  <= '0;
            squash_count_q <= '0;
        end else begin
            if (consume) fetch_count_q <= fetch_count_q + 32'd1;
            if (discard) squash_count_q <= squash_count_q + 16'd1;
        end
    end

    assign fetch_count  = fetch_count_q;
    assign squash_count = squash_count_q;
`endif

    assign imem_req   = (state_q == StFetch);
    assign imem_addr  = pc;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign pc4        = inst_pc_q + ADDR_W'(4);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_b;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc4;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [15:0] squash_count;
`endif

    int errors = 0;
    int checks = 0;

    fetch_sequencer #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
`ifdef FETCH_PERF_EN
        .fetch_count    (fetch_count),
        .squash_count   (squash_count),
`endif
        .pc4            (pc4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_b          = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;
        #1 rst_b = 1'b0;
        tick();
        tick();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_addr", imem_addr, 0);
        rst_b = 1'b1;

        // Zero-wait memory: one instruction every 2 cycles.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("zw_req", imem_req, 1);
            chk("zw_addr", imem_addr, 32'(4 * i));
            chk("zw_valid_lo", inst_valid, 0);
            imem_ack   = 1'b1;
            imem_rdata = word(32'(4 * i));
            tick();
            imem_ack = 1'b0;
            chk("zw_valid", inst_valid, 1);
            chk("zw_inst_pc", inst_pc, 32'(4 * i));
            chk("zw_inst", inst, word(32'(4 * i)));
            chk("zw_pc4", pc4, 32'(4 * i + 4));
            chk("zw_req_lo", imem_req, 0);
        end

        // Ack arrives on the 4th request cycle.
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mc_req", imem_req, 1);
            chk("mc_addr", imem_addr, 32'h10);
            chk("mc_valid_lo", inst_valid, 0);
            if (k == 3) begin
                imem_ack   = 1'b1;
                imem_rdata = word(32'h10);
            end
        end
        tick();
        imem_ack = 1'b0;
        chk("mc_valid", inst_valid, 1);
        chk("mc_inst_pc", inst_pc, 32'h10);
        chk("mc_inst", inst, word(32'h10));

        // Stall holds the instruction and blocks new requests.
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("st_valid", inst_valid, 1);
            chk("st_inst_pc", inst_pc, 32'h10);
            chk("st_inst", inst, word(32'h10));
            chk("st_req", imem_req, 0);
        end
        stall = 1'b0;
        tick();
        chk("st_rel_req", imem_req, 1);
        chk("st_rel_addr", imem_addr, 32'h14);
        chk("st_rel_valid", inst_valid, 0);

        // Fetch 0x14, then redirect from HOLD to 0x8.
        imem_ack   = 1'b1;
        imem_rdata = word(32'h14);
        tick();
        imem_ack = 1'b0;
        chk("r8_pre_inst_pc", inst_pc, 32'h14);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8;
        tick();
        redirect_valid = 1'b0;
        chk("r8_valid", inst_valid, 0);
        chk("r8_req", imem_req, 1);
        chk("r8_addr", imem_addr, 32'h8);

        // Redirect to 0x100 while fetch of 0x8 is pending; the 0x8 word must be dropped.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("sq_req", imem_req, 1);
        chk("sq_addr", imem_addr, 32'h100);
        imem_ack   = 1'b1;
        imem_rdata = word(32'h8);
        tick();
        imem_ack = 1'b0;
        chk("sq_valid_lo", inst_valid, 0);
        chk("sq_req2", imem_req, 1);
        chk("sq_addr2", imem_addr, 32'h100);
        imem_ack   = 1'b1;
        imem_rdata = word(32'h100);
        tick();
        imem_ack = 1'b0;
        chk("sq_valid", inst_valid, 1);
        chk("sq_inst_pc", inst_pc, 32'h100);
        chk("sq_inst", inst, word(32'h100));

        // Redirect with stall in HOLD: flush wins, target aligned.
        stall = 1'b1;
        tick();
        chk("rs_hold_valid", inst_valid, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        chk("rs_valid", inst_valid, 0);
        chk("rs_req", imem_req, 1);
        chk("rs_addr", imem_addr, 32'h200);

        // Redirect in the same cycle as ack: data dropped, no squash left behind.
        imem_ack       = 1'b1;
        imem_rdata     = word(32'h200);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        chk("ra_valid", inst_valid, 0);
        chk("ra_addr", imem_addr, 32'h300);
        imem_ack   = 1'b1;
        imem_rdata = word(32'h300);
        tick();
        imem_ack = 1'b0;
        chk("ra_valid2", inst_valid, 1);
        chk("ra_inst_pc", inst_pc, 32'h300);
        chk("ra_inst", inst, word(32'h300));

        // PC wraps past the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack   = 1'b1;
        imem_rdata = word(32'hFFFF_FFFC);
        tick();
        imem_ack = 1'b0;
        chk("wr_inst_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wr_pc4", pc4, 32'h0);
        tick();
        chk("wr_req", imem_req, 1);
        chk("wr_next_addr", imem_addr, 32'h0);

        // Async reset mid-FETCH with a squash pending.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h44;
        tick();
        redirect_valid = 1'b0;
        chk("ar_pre_addr", imem_addr, 32'h44);
        #2 rst_b = 1'b0;
        #1;
        chk("ar_req", imem_req, 0);
        chk("ar_valid", inst_valid, 0);
        chk("ar_addr", imem_addr, 32'h0);
        chk("ar_inst", inst, 32'h0);
        chk("ar_inst_pc", inst_pc, 32'h0);
        tick();
        rst_b = 1'b1;
        tick();
        chk("ar_restart_req", imem_req, 1);
        chk("ar_restart_addr", imem_addr, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = word(32'h0);
        tick();
        imem_ack = 1'b0;
        chk("ar_restart_valid", inst_valid, 1);
        chk("ar_restart_inst_pc", inst_pc, 32'h0);
        chk("ar_restart_inst", inst, word(32'h0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that owns the program counter and sequences the instruction-memory port. Uses a req/ack handshake toward imem, so single-cycle and multi-cycle memories are both supported. Delivers one instruction at a time to decode through a valid/stall output register. Applies branch/jump redirects from EX, squashing wrong-path fetches, including one still in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_b  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  32  fetch address; always equals internal pc.
imem_ack  in  1  memory completes the request this cycle; imem_rdata valid; may be asserted in the same cycle as imem_req.
imem_rdata  in  32  instruction word.
redirect_valid  in  1  single-cycle pulse from EX: taken branch, jump or jr.
redirect_pc  in  32  redirect target.
stall  in  1  decode cannot accept; the held instruction is consumed in a cycle where inst_valid=1 and stall=0.
inst_valid  out  1  inst/inst_pc/pc4 hold a valid instruction.
inst  out  32  fetched instruction.
inst_pc  out  32  address of inst.
pc4  out  32  inst_pc+4, combinational, for link writes.

Behaviour:
- Reset (async, rst_b=0):
  - pc=RESET_PC; state=IDLE; squash=0.
  - imem_req=0, inst_valid=0, inst=0, inst_pc=0.
- States: IDLE, FETCH, HOLD.
  - imem_req=1 exactly when state=FETCH.
- IDLE:
  - Entered only from reset; always goes to FETCH next cycle.
  - A redirect in IDLE updates pc.
- FETCH:
  - imem_addr stays stable and imem_req stays high until ack. The request is never withdrawn.
  - On ack with squash=0 and no redirect:
    - inst<=imem_rdata, inst_pc<=pc, inst_valid<=1.
    - pc<=pc+4 (mod 2^32; wraps from 32'hFFFF_FFFC to 0).
    - state<=HOLD.
  - On ack with squash=1: data discarded; squash<=0; stay in FETCH (new request at updated pc next cycle).
- HOLD:
  - stall=0: inst_valid<=0, state<=FETCH.
  - stall=1: hold all outputs unchanged.
- Throughput: with zero-wait memory (ack in same cycle as req), one instruction per 2 cycles.
  - Fetch latency from request to inst_valid = ack cycle + 1.
- Redirect has the highest priority and applies in any state:
  - pc<={redirect_pc[31:2],2'b00}; inst_valid<=0.
  - HOLD: state<=FETCH.
  - FETCH without ack this cycle: squash<=1. The request completes at the old address and is discarded.
  - FETCH with ack this cycle: data discarded, squash stays 0, stay in FETCH at the new pc.
  - Redirect while squash=1: pc takes the newest target; squash remains 1.
- Redirect and stall in the same cycle: redirect wins; the held instruction is flushed, not consumed.
- Reset mid-transaction: req drops immediately. The memory must tolerate an abandoned request.

Optional Feature:
FETCH_PERF_EN
- Defined: adds output ports fetch_count[31:0] and squash_count[15:0], both reset to 0.
  - fetch_count increments on each consumed instruction (inst_valid & !stall & !redirect_valid).
  - squash_count increments on each discarded ack or flushed valid instruction.
  - Both wrap silently on overflow.
- Undefined: neither the ports nor the counters exist.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch_state_t enum (IDLE, FETCH, HOLD).
  - INST_W=32, ADDR_W=32.
  - DEFAULT_RESET_PC.
- One sub-module, fetch_pc_reg: the pc register plus next-pc mux (redirect / pc+4 / hold), with async reset to RESET_PC.

Test Plan:
- Reset release, memory acks every req in the same cycle, stall=0 -> inst_valid pulses with inst_pc 0,4,8,12 every 2 cycles; pc4 = 4,8,12,16.
- Memory acks 3 cycles after req -> imem_addr held stable and imem_req high for all 4 cycles; inst_valid rises the cycle after ack.
- inst_valid=1 with stall held 5 cycles -> inst/inst_pc unchanged, imem_req=0; on the cycle after stall falls, a req is issued to inst_pc+4.
- Redirect to 32'h0000_0100 while a FETCH to 0x8 waits on a 2-cycle ack -> the ack'd word at 0x8 is never presented; the next req addresses 0x100; inst_pc of the next valid = 0x100.
- Redirect to 32'h0000_0203 while in HOLD with stall=1 -> inst_valid drops next cycle; req to 0x200.
- Assert rst_b=0 mid-FETCH -> imem_req=0 and inst_valid=0 immediately (async); after release, fetch restarts at RESET_PC.
